// File: rtl/mem_bus_arbiter_if.sv
// One Avalon-style memory port: address/strobes/data from the master side,
// waitrequest/readdata back from the slave side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for one Avalon-style memory bus. A grant is
// held for a whole transaction; every transaction returns through IDLE.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter bit M0_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_arbiter_if.slave     m0,
  mem_bus_arbiter_if.slave     m1,
  mem_bus_arbiter_if.master    bus,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_0 = 2'd1,
    OWN_1 = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   last_owner_reg, last_owner_next;

  logic req0, req1;
  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= M0_FIRST;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // A dropped request releases the bus without counting as a completed turn.
  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && req1)
          state_next = last_owner_reg ? OWN_0 : OWN_1;
        else if (req0)
          state_next = OWN_0;
        else if (req1)
          state_next = OWN_1;
      end
      OWN_0: begin
        if (!req0) begin
          state_next = IDLE;
        end else if (!bus.waitrequest) begin
          state_next      = IDLE;
          last_owner_next = 1'b0;
        end
      end
      OWN_1: begin
        if (!req1) begin
          state_next = IDLE;
        end else if (!bus.waitrequest) begin
          state_next      = IDLE;
          last_owner_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant          = 2'b00;
    bus.address    = {ADDR_W{1'b0}};
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = {DATA_W{1'b0}};
    bus.byteenable = {(DATA_W/8){1'b0}};
    m0.waitrequest = 1'b1;
    m0.readdata    = {DATA_W{1'b0}};
    m1.waitrequest = 1'b1;
    m1.readdata    = {DATA_W{1'b0}};
    case (state_reg)
      OWN_0: begin
        grant          = 2'b01;
        bus.address    = m0.address;
        bus.read       = m0.read;
        bus.write      = m0.write;
        bus.writedata  = m0.writedata;
        bus.byteenable = m0.byteenable;
        m0.waitrequest = bus.waitrequest;
        m0.readdata    = bus.readdata;
      end
      OWN_1: begin
        grant          = 2'b10;
        bus.address    = m1.address;
        bus.read       = m1.read;
        bus.write      = m1.write;
        bus.writedata  = m1.writedata;
        bus.byteenable = m1.byteenable;
        m1.waitrequest = bus.waitrequest;
        m1.readdata    = bus.readdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: two protocol-following masters and a
// random-stall slave, checked every cycle against a transaction-level owner model.
module tb_mem_bus_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam bit M0_FIRST = 1'b1;
  localparam int N_CYC    = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .M0_FIRST(M0_FIRST)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .bus   (bus_if),
    .grant (grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Stimulus state of each master: one outstanding request at a time.
  logic              m_act [2];
  logic [ADDR_W-1:0] m_addr[2];
  logic [DATA_W-1:0] m_wd  [2];
  logic [BE_W-1:0]   m_be  [2];
  logic              m_rd  [2];
  logic              m_wr  [2];
  logic              m_done[2];
  logic              s_wait;
  logic [DATA_W-1:0] s_rdata;

  // Reference: who owns the bus (-1 none) and who last completed a turn.
  int own;
  int last;

  task automatic drive_inputs();
    m0_if.address    = m_addr[0];
    m0_if.read       = m_act[0] & m_rd[0];
    m0_if.write      = m_act[0] & m_wr[0];
    m0_if.writedata  = m_wd[0];
    m0_if.byteenable = m_be[0];
    m1_if.address    = m_addr[1];
    m1_if.read       = m_act[1] & m_rd[1];
    m1_if.write      = m_act[1] & m_wr[1];
    m1_if.writedata  = m_wd[1];
    m1_if.byteenable = m_be[1];
    bus_if.waitrequest = s_wait;
    bus_if.readdata    = s_rdata;
  endtask

  task automatic new_request(input int n);
    int k;
    k = $urandom_range(0, 9);
    m_act[n]  = 1'b1;
    m_addr[n] = $urandom;
    m_wd[n]   = $urandom;
    m_be[n]   = BE_W'($urandom_range(0, (1 << BE_W) - 1));
    m_rd[n]   = (k <= 4) || (k == 9);
    m_wr[n]   = (k >= 5);
  endtask

  initial begin
    int  cyc;
    int  start_pct;
    int  drop_div;
    bit  req[2];
    logic [1:0]        e_grant;
    logic [ADDR_W-1:0] e_addr;
    logic              e_rd, e_wr;
    logic [DATA_W-1:0] e_wd;
    logic [BE_W-1:0]   e_be;
    logic              e_mw[2];
    logic [DATA_W-1:0] e_mr[2];

    for (int n = 0; n < 2; n++) begin
      m_act[n] = 1'b0; m_addr[n] = '0; m_wd[n] = '0; m_be[n] = '0;
      m_rd[n] = 1'b0; m_wr[n] = 1'b0; m_done[n] = 1'b0;
    end
    s_wait  = 1'b0;
    s_rdata = '0;
    reset   = 1'b1;
    drive_inputs();
    @(posedge clk); #1;
    own  = -1;
    last = M0_FIRST ? 1 : 0;

    for (cyc = 0; cyc < N_CYC; cyc++) begin
      // ---- sample and check, away from the active edge ----
      @(negedge clk);
      for (int n = 0; n < 2; n++) req[n] = m_act[n] & (m_rd[n] | m_wr[n]);
      e_grant = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wd = '0; e_be = '0;
      if (own >= 0) begin
        e_addr = m_addr[own];
        e_rd   = m_act[own] & m_rd[own];
        e_wr   = m_act[own] & m_wr[own];
        e_wd   = m_wd[own];
        e_be   = m_be[own];
      end
      for (int n = 0; n < 2; n++) begin
        e_mw[n] = (own == n) ? s_wait : 1'b1;
        e_mr[n] = (own == n) ? s_rdata : '0;
      end
      check_val("grant",      64'(grant),              64'(e_grant));
      check_val("address",    64'(bus_if.address),     64'(e_addr));
      check_val("read",       64'(bus_if.read),        64'(e_rd));
      check_val("write",      64'(bus_if.write),       64'(e_wr));
      check_val("writedata",  64'(bus_if.writedata),   64'(e_wd));
      check_val("byteenable", 64'(bus_if.byteenable),  64'(e_be));
      check_val("m0_wait",    64'(m0_if.waitrequest),  64'(e_mw[0]));
      check_val("m0_rdata",   64'(m0_if.readdata),     64'(e_mr[0]));
      check_val("m1_wait",    64'(m1_if.waitrequest),  64'(e_mw[1]));
      check_val("m1_rdata",   64'(m1_if.readdata),     64'(e_mr[1]));

      for (int n = 0; n < 2; n++) begin
        m_done[n] = req[n] && !e_mw[n];
        if (m_done[n])
          $display("txn m%0d %s addr=%08h wd=%08h be=%h rd=%08h cyc=%0d", n,
                   (m_rd[n] && m_wr[n]) ? "RW" : m_rd[n] ? "RD" : "WR",
                   m_addr[n], m_wd[n], m_be[n], s_rdata, cyc);
      end

      // ---- reference transition, from the arbitration rules ----
      if (reset) begin
        own  = -1;
        last = M0_FIRST ? 1 : 0;
      end else if (own < 0) begin
        if (req[0] && req[1]) own = 1 - last;
        else if (req[0])      own = 0;
        else if (req[1])      own = 1;
      end else if (!req[own]) begin
        own = -1;
      end else if (!s_wait) begin
        last = own;
        own  = -1;
      end

      // ---- next stimulus, just after the edge ----
      @(posedge clk); #1;
      // Early phase keeps both masters saturated to exercise strict alternation.
      start_pct = (cyc < 400) ? 100 : 60;
      drop_div  = (cyc < 400) ? 0 : 30;
      for (int n = 0; n < 2; n++) begin
        if (m_done[n]) m_act[n] = 1'b0;
        if (m_act[n] && drop_div != 0 && $urandom_range(0, drop_div - 1) == 0)
          m_act[n] = 1'b0;
        else if (!m_act[n] && $urandom_range(0, 99) < start_pct)
          new_request(n);
        if (!m_act[n]) m_addr[n] = $urandom;
      end
      s_wait  = ($urandom_range(0, 99) < 45);
      s_rdata = $urandom;
      reset   = (cyc == 0) || (cyc > 400 && $urandom_range(0, 79) == 0);
      drive_inputs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
